// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: ALU opcodes, FSM state
// encoding and the default datapath geometry.
package fir_pkg;
  localparam int NTAPS_D = 64;
  localparam int DW_D    = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// ALU issue bus between the tap sequencer (master) and the 16-bit ALU (slave).
//   alu_opcode/alu_opA/alu_opB/alu_en : issued op, master -> slave
//   alu_result/alu_carry              : combinational result, slave -> master
interface fir_tap_sequencer_if #(
  parameter int DW = 16
);
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_opA;
  logic [DW-1:0] alu_opB;
  logic          alu_en;
  logic [DW-1:0] alu_result;
  logic          alu_carry;

  modport master (
    output alu_opcode, alu_opA, alu_opB, alu_en,
    input  alu_result, alu_carry
  );
  modport slave (
    input  alu_opcode, alu_opA, alu_opB, alu_en,
    output alu_result, alu_carry
  );
endinterface

// File: rtl/fir_delay_line.sv
// NTAPS x DW circular sample buffer.
//   wr_en/wr_data : advance head and store the new sample at the new head
//   rd_tap        : tap offset; rd_data = buf[(head - rd_tap) mod NTAPS]
// Offset 0 is therefore always the newest sample.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_D,
  parameter int DW    = DW_D,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_tap,
  output logic [DW-1:0] rd_data
);
  logic [NTAPS-1:0][DW-1:0] mem;
  logic [AW-1:0]            head;
  logic [AW-1:0]            head_nxt;
  logic [AW-1:0]            rd_idx;

  // NTAPS is a power of two, so AW-bit arithmetic gives the mod-NTAPS wrap.
  assign head_nxt = head + AW'(1);
  assign rd_idx   = head - rd_tap;
  assign rd_data  = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      mem  <= '0;
    end else if (wr_en) begin
      head          <= head_nxt;
      mem[head_nxt] <= wr_data;
    end
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts one sample, walks all taps issuing MUL then ADD
// to an external ALU, accumulates, then offers the result on y_* handshake.
//   clk, rst_n                      : clock, async active-low reset
//   sample_in/sample_valid/ready    : input sample handshake (ready only in IDLE)
//   coef_addr/coef_data             : coefficient ROM, combinational read
//   alu                             : ALU issue bus (master side)
//   y_out/y_ovf/y_valid/y_ready     : filter output handshake; y_ovf is sticky carry
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_D,
  parameter int DW    = DW_D,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [AW-1:0]        coef_addr,
  input  logic [DW-1:0]        coef_data,
  fir_tap_sequencer_if.master  alu,
  output logic [DW-1:0]        y_out,
  output logic                 y_ovf,
  output logic                 y_valid,
  input  logic                 y_ready
);
  state_t        state, nstate;
  logic [AW-1:0] tap;
  logic [DW-1:0] acc;
  logic [DW-1:0] prod;
  logic          ovf;
  logic          wr_en;
  logic [DW-1:0] rd_data;
  logic          last_tap;

  assign last_tap = (tap == AW'(NTAPS - 1));

  fir_delay_line #(.NTAPS(NTAPS), .DW(DW), .AW(AW)) u_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (sample_in),
    .rd_tap  (tap),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tap   <= '0;
      acc   <= '0;
      prod  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        S_IDLE: if (sample_valid) begin
          acc <= '0;
          ovf <= 1'b0;
          tap <= '0;
        end
        S_MUL: prod <= alu.alu_result;
        S_ADD: begin
          acc <= alu.alu_result;
          if (alu.alu_carry) ovf <= 1'b1;
          if (!last_tap) tap <= tap + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are all forced to zero outside their owning state so that a
  // partially built accumulator is never visible on y_out.
  always_comb begin
    nstate         = state;
    sample_ready   = 1'b0;
    wr_en          = 1'b0;
    coef_addr      = '0;
    alu.alu_en     = 1'b0;
    alu.alu_opcode = OP_ADD;
    alu.alu_opA    = '0;
    alu.alu_opB    = '0;
    y_valid        = 1'b0;
    y_out          = '0;
    y_ovf          = 1'b0;
    case (state)
      S_IDLE: begin
        sample_ready = 1'b1;
        wr_en        = sample_valid;
        if (sample_valid) nstate = S_MUL;
      end
      S_MUL: begin
        alu.alu_en     = 1'b1;
        alu.alu_opcode = OP_MUL;
        alu.alu_opA    = rd_data;
        alu.alu_opB    = coef_data;
        coef_addr      = tap;
        nstate         = S_ADD;
      end
      S_ADD: begin
        alu.alu_en     = 1'b1;
        alu.alu_opcode = OP_ADD;
        alu.alu_opA    = acc;
        alu.alu_opB    = prod;
        coef_addr      = tap;
        nstate         = last_tap ? S_DONE : S_MUL;
      end
      S_DONE: begin
        y_valid = 1'b1;
        y_out   = acc;
        y_ovf   = ovf;
        if (y_ready) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural ALU + coefficient ROM, a direct
// convolution model (history queue, per-tap modular sums with carry tracking)
// and one negedge compare process, plus literal expectations per scenario.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] sample_in = 0;
  logic        sample_valid = 0;
  logic        sample_ready;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] y_out;
  logic        y_ovf;
  logic        y_valid;
  logic        y_ready = 1;

  logic [15:0] h [64];

  fir_tap_sequencer_if alu_bus ();

  fir_tap_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .alu          (alu_bus.master),
    .y_out        (y_out),
    .y_ovf        (y_ovf),
    .y_valid      (y_valid),
    .y_ready      (y_ready)
  );

  always #5 clk = ~clk;

  assign coef_data = h[coef_addr];

  // Behavioural ALU: ADD and MUL only, low 16 bits, carry from the ADD.
  always_comb begin
    logic [31:0] p;
    logic [16:0] s;
    p = alu_bus.alu_opA * alu_bus.alu_opB;
    s = {1'b0, alu_bus.alu_opA} + {1'b0, alu_bus.alu_opB};
    alu_bus.alu_result = (alu_bus.alu_opcode == OP_MUL) ? p[15:0] : s[15:0];
    alu_bus.alu_carry  = (alu_bus.alu_opcode == OP_ADD) ? s[16] : 1'b0;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] hist [$];   // hist[k] = x[n-k]
  logic [15:0] expq [$];
  logic        expo [$];
  logic [15:0] got_y [$];
  logic        got_o [$];

  task automatic model_push(input logic [15:0] x);
    logic [15:0] acc, xv;
    logic [31:0] p;
    logic [16:0] s;
    logic        ovf;
    hist.push_front(x);
    if (hist.size() > 64) void'(hist.pop_back());
    acc = 0;
    ovf = 0;
    for (int k = 0; k < 64; k++) begin
      xv = (k < hist.size()) ? hist[k] : 16'h0;
      p  = h[k] * xv;
      s  = {1'b0, acc} + {1'b0, p[15:0]};
      if (s[16]) ovf = 1;
      acc = s[15:0];
    end
    expq.push_back(acc);
    expo.push_back(ovf);
  endtask

  // ---------------- compare process ----------------
  int          cyc = 0;
  int          acc_cyc = 0;
  int          alu_cnt = 0;
  logic        prev_yv = 0, prev_yr = 0;
  logic [15:0] prev_y = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      expq.delete();
      expo.delete();
      alu_cnt = 0;
      prev_yv = 0;
      prev_yr = 0;
    end else begin
      cyc++;
      if (prev_yv && !prev_yr) begin
        chk("hold_valid", y_valid, 1);
        chk("hold_y", y_out, prev_y);
      end
      if (prev_yv && prev_yr) chk("idle_after_done", sample_ready, 1);
      if (alu_bus.alu_en) begin
        alu_cnt++;
        chk("opcode_seq", alu_bus.alu_opcode, (alu_cnt % 2 == 1) ? OP_MUL : OP_ADD);
        chk("coef_addr", coef_addr, (alu_cnt - 1) / 2);
      end else begin
        chk("alu_quiet", {alu_bus.alu_opcode, alu_bus.alu_opA, alu_bus.alu_opB}, 0);
      end
      if (sample_ready) chk("ready_excl", {alu_bus.alu_en, y_valid}, 0);
      if (y_valid) begin
        chk("busy_in_done", {sample_ready, alu_bus.alu_en}, 0);
        if (expq.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          if (!prev_yv) begin
            chk("latency", cyc - acc_cyc, 129);
            chk("alu_cycles", alu_cnt, 128);
          end
          chk("y_out", y_out, expq[0]);
          chk("y_ovf", y_ovf, expo[0]);
          if (y_ready) begin
            got_y.push_back(y_out);
            got_o.push_back(y_ovf);
            void'(expq.pop_front());
            void'(expo.pop_front());
          end
        end
      end
      if (sample_valid && sample_ready) begin
        model_push(sample_in);
        acc_cyc = cyc;
        alu_cnt = 0;
      end
      prev_yv = y_valid;
      prev_yr = y_ready;
      prev_y  = y_out;
    end
  end

  // ---------------- driver ----------------
  logic rnd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) y_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 0;
    sample_valid = 0;
    y_ready = 1;
    rnd = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    got_y.delete();
    got_o.delete();
  endtask

  task automatic send(input logic [15:0] v);
    int   n;
    logic ok;
    sample_in = v;
    sample_valid = 1;
    n = 0;
    ok = 0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = sample_ready;
      tick();
      n++;
    end
    sample_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got_y.size() < n && k < 30000) begin
      tick();
      k++;
    end
    if (got_y.size() < n) chk("out_timeout", got_y.size(), n);
  endtask

  task automatic set_h_ones();
    for (int k = 0; k < 64; k++) h[k] = 16'd1;
  endtask

  initial begin
    set_h_ones();

    // 1. reset state
    do_reset();
    chk("rst_sample_ready", sample_ready, 1);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_y_ovf", y_ovf, 0);
    chk("rst_alu_en", alu_bus.alu_en, 0);
    chk("rst_coef_addr", coef_addr, 0);

    // 2. impulse
    send(16'd5);
    wait_out(1);
    chk("impulse_y", got_y[0], 16'd5);
    chk("impulse_ovf", got_o[0], 0);

    // 3. step through pointer wrap
    do_reset();
    for (int k = 0; k < 64; k++) h[k] = 16'(k + 1);
    for (int i = 0; i < 70; i++) send(16'd1);
    wait_out(70);
    chk("step_1", got_y[0], 16'd1);
    chk("step_2", got_y[1], 16'd3);
    chk("step_3", got_y[2], 16'd6);
    for (int i = 63; i < 70; i++) chk("step_sat", got_y[i], 16'h0820);

    // 4. overflow
    do_reset();
    set_h_ones();
    send(16'h8000);
    send(16'h8000);
    wait_out(2);
    chk("ovf_y0", got_y[0], 16'h8000);
    chk("ovf_o0", got_o[0], 0);
    chk("ovf_y1", got_y[1], 16'h0000);
    chk("ovf_o1", got_o[1], 1);

    // 5. backpressure with a sample waiting
    do_reset();
    y_ready = 0;
    send(16'd3);
    for (int k = 0; k < 300 && !y_valid; k++) tick();
    chk("bp_reach_done", y_valid, 1);
    sample_in = 16'd9;
    sample_valid = 1;
    repeat (50) begin
      tick();
      chk("bp_no_take", sample_ready, 0);
    end
    y_ready = 1;
    send(16'd9);
    wait_out(2);
    chk("bp_y0", got_y[0], 16'd3);
    chk("bp_y1", got_y[1], 16'd12);

    // 6. reset in the middle of tap 30
    do_reset();
    send(16'd7);
    repeat (61) tick();
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_alu", {alu_bus.alu_en, alu_bus.alu_opcode, alu_bus.alu_opA, alu_bus.alu_opB}, 0);
    chk("mid_rst_y", {y_valid, y_ovf, y_out}, 0);
    chk("mid_rst_coef", coef_addr, 0);
    tick();
    rst_n = 1;
    tick();
    got_y.delete();
    got_o.delete();
    send(16'd5);
    wait_out(1);
    chk("mid_rst_rerun", got_y[0], 16'd5);

    // 7. randomized coefficients, samples, gaps and backpressure
    do_reset();
    for (int k = 0; k < 64; k++) h[k] = 16'($urandom);
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(16'($urandom));
    end
    wait_out(40);
    rnd = 0;
    y_ready = 1;
    chk("rand_count", got_y.size(), 40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
